// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel bundle for pipe_stage_reg: upstream in_* and downstream out_* sides.
// Handshake: a word moves on a rising edge where valid && ready; valid must not depend on ready.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_halt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_halt;

    modport slave (
        input  in_valid, in_data, in_halt, out_ready,
        output in_ready, out_valid, out_data, out_halt
    );

    modport master (
        output in_valid, in_data, in_halt, out_ready,
        input  in_ready, out_valid, out_data, out_halt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline stage with per-word halt tag and sticky halted flag.
// Define PIPE_STAGE_FLUSH_EN to add the flush port that squashes all held words.
module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipe_stage_reg_if.slave      bus,
`ifdef PIPE_STAGE_FLUSH_EN
    input  logic                 flush,
`endif
    output logic [1:0]           occupancy,
    output logic                 halted
);
    logic             main_v_q,    main_v_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_halt_q, main_halt_d;
    logic             skid_v_q,    skid_v_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_halt_q, skid_halt_d;
    logic             halt_seen_q, halt_seen_d;
    logic             halted_q,    halted_d;

    logic flush_w;
    logic in_ready_w;
    logic accept;
    logic send;

`ifdef PIPE_STAGE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // in_ready comes only from registers so it never forms a combinational path from out_ready.
    assign in_ready_w = !skid_v_q && !halt_seen_q && !halted_q;
    assign accept     = bus.in_valid && in_ready_w;
    assign send       = main_v_q && bus.out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_halt_d = main_halt_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_halt_d = skid_halt_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q || (send && main_halt_q);

        if (send && skid_v_q) begin
            main_data_d = skid_data_q;
            main_halt_d = skid_halt_q;
            skid_v_d    = 1'b0;
        end else if (accept && (!main_v_q || send)) begin
            main_v_d    = 1'b1;
            main_data_d = bus.in_data;
            main_halt_d = bus.in_halt;
        end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_data_d = bus.in_data;
            skid_halt_d = bus.in_halt;
        end else if (send) begin
            main_v_d = 1'b0;
        end

        if (accept && bus.in_halt) begin
            halt_seen_d = 1'b1;
        end

        // A halt word already taken downstream keeps the stage frozen; an unsent one is squashed.
        if (flush_w) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (!(halted_q || (send && main_halt_q))) begin
                halt_seen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_halt_q <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_halt_q <= 1'b0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_halt_q <= main_halt_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_halt_q <= skid_halt_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = main_v_q;
    assign bus.out_data  = main_data_q;
    assign bus.out_halt  = main_halt_q;
    assign occupancy     = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign halted        = halted_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a FIFO reference model.
// Flush scenarios are compiled in when PIPE_STAGE_FLUSH_EN is defined.
module tb_pipe_stage_reg;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst_r = 1'b1;
    logic       flush_r = 1'b0;
    logic [1:0] occ;
    logic       halted;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(W)) bus ();

    pipe_stage_reg #(.WIDTH(W)) dut (
        .CLK       (clk),
        .RST       (rst_r),
        .bus       (bus),
`ifdef PIPE_STAGE_FLUSH_EN
        .flush     (flush_r),
`endif
        .occupancy (occ),
        .halted    (halted)
    );

    // Reference model: held words in acceptance order, each {halt, data}.
    logic [W:0] exp_q[$];
    bit         m_halt_seen;
    bit         m_halted;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    function automatic logic m_in_ready();
        return (exp_q.size() < 2) && !m_halt_seen && !m_halted;
    endfunction

    // Drive one cycle of inputs and advance the model across the rising edge.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic h,
                        input logic ordy, input logic fl);
        logic acc, snd, snd_halt;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_halt   = h;
        bus.out_ready = ordy;
        flush_r       = fl;
        acc      = iv && m_in_ready();
        snd      = (exp_q.size() > 0) && ordy;
        snd_halt = snd ? exp_q[0][W] : 1'b0;
        @(posedge clk);
        if (rst_r) begin
            exp_q.delete();
            m_halt_seen = 0;
            m_halted    = 0;
        end else begin
            if (snd) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({h, d});
            if (acc && h) m_halt_seen = 1;
            if (fl) begin
                exp_q.delete();
                if (!(m_halted || snd_halt)) m_halt_seen = 0;
            end
            if (snd_halt) m_halted = 1;
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, 1'b0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        rst_r = 1'b1;
        idle(1'b0);
        rst_r = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if ({bus.out_valid, occ, bus.in_ready, halted, bus.out_halt} !== 6'b0_00_1_0_0)
            $display("FAIL reset_ctrl: got v=%b occ=%0d rdy=%b halted=%b oh=%b, want v=0 occ=0 rdy=1 halted=0 oh=0",
                     bus.out_valid, occ, bus.in_ready, halted, bus.out_halt);
        else pass_cnt++;
        chk_cnt++;
        if (bus.out_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", bus.out_data);
        else pass_cnt++;
        step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (occ !== 2'd2) $display("FAIL fill_occ: got %0d want 2", occ);
        else pass_cnt++;
        do_reset();
        chk_cnt++;
        if ({bus.out_valid, occ, bus.in_ready, halted} !== 5'b0_00_1_0 || bus.out_data !== 32'h0)
            $display("FAIL reset_mid: got v=%b occ=%0d rdy=%b halted=%b data=%h, want v=0 occ=0 rdy=1 halted=0 data=0",
                     bus.out_valid, occ, bus.in_ready, halted, bus.out_data);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
            chk_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== W'(i) || occ !== 2'd1 || bus.in_ready !== 1'b1)
                $display("FAIL stream_%0d: got v=%b data=%h occ=%0d rdy=%b, want v=1 data=%h occ=1 rdy=1",
                         i, bus.out_valid, bus.out_data, occ, bus.in_ready, W'(i));
            else pass_cnt++;
        end
        idle(1'b1);
        chk_cnt++;
        if (bus.out_valid !== 1'b0 || occ !== 2'd0) $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", bus.out_valid, occ);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        step(1'b1, 32'h0000_00A1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_00A2, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (occ !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 32'hA1)
            $display("FAIL bp_absorb: got occ=%0d rdy=%b data=%h want occ=2 rdy=0 data=000000a1", occ, bus.in_ready, bus.out_data);
        else pass_cnt++;
        step(1'b1, 32'h0000_00A3, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (occ !== 2'd2 || bus.out_data !== 32'hA1) $display("FAIL bp_hold: got occ=%0d data=%h want occ=2 data=000000a1", occ, bus.out_data);
        else pass_cnt++;
        idle(1'b1);
        chk_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA2 || occ !== 2'd1 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release: got v=%b data=%h occ=%0d rdy=%b want v=1 data=000000a2 occ=1 rdy=1",
                     bus.out_valid, bus.out_data, occ, bus.in_ready);
        else pass_cnt++;
        idle(1'b1);
        chk_cnt++;
        if (bus.out_valid !== 1'b0 || occ !== 2'd0) $display("FAIL bp_drain: got v=%b occ=%0d want v=0 occ=0", bus.out_valid, occ);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        step(1'b1, 32'h0000_00B1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_00B2, 1'b0, 1'b1, 1'b0);
        chk_cnt++;
        if (occ !== 2'd1 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hB2)
            $display("FAIL simul: got occ=%0d v=%b data=%h want occ=1 v=1 data=000000b2", occ, bus.out_valid, bus.out_data);
        else pass_cnt++;
        idle(1'b1);
    endtask

    task automatic test_random();
        logic fl;
        for (int n = 0; n < 400; n++) begin
`ifdef PIPE_STAGE_FLUSH_EN
            fl = ($urandom_range(0, 19) == 0);
`else
            fl = 1'b0;
`endif
            step($urandom_range(0, 3) != 0, $urandom, 1'b0, $urandom_range(0, 3) != 0, fl);
            chk_cnt++;
            if (bus.out_valid !== (exp_q.size() > 0) || occ !== 2'(exp_q.size()) ||
                bus.in_ready !== m_in_ready() || halted !== m_halted)
                $display("FAIL rand_ctrl_%0d: got v=%b occ=%0d rdy=%b halted=%b want v=%b occ=%0d rdy=%b halted=%b",
                         n, bus.out_valid, occ, bus.in_ready, halted, exp_q.size() > 0, exp_q.size(), m_in_ready(), m_halted);
            else pass_cnt++;
            if (exp_q.size() > 0) begin
                chk_cnt++;
                if ({bus.out_halt, bus.out_data} !== exp_q[0])
                    $display("FAIL rand_data_%0d: got %h want %h", n, {bus.out_halt, bus.out_data}, exp_q[0]);
                else pass_cnt++;
            end
        end
        idle(1'b1);
        idle(1'b1);
    endtask

`ifdef PIPE_STAGE_FLUSH_EN
    task automatic test_flush();
        step(1'b1, 32'h0000_00C1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_00C2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_00C3, 1'b0, 1'b0, 1'b1);
        chk_cnt++;
        if (occ !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_clear: got occ=%0d v=%b rdy=%b want occ=0 v=0 rdy=1", occ, bus.out_valid, bus.in_ready);
        else pass_cnt++;
        idle(1'b1);
        chk_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_discard: got v=%b want 0", bus.out_valid);
        else pass_cnt++;
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL flush_halt_pend: got rdy=%b want 0", bus.in_ready);
        else pass_cnt++;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk_cnt++;
        if (bus.in_ready !== 1'b1 || occ !== 2'd0 || halted !== 1'b0)
            $display("FAIL flush_halt_clear: got rdy=%b occ=%0d halted=%b want rdy=1 occ=0 halted=0", bus.in_ready, occ, halted);
        else pass_cnt++;
    endtask
`endif

    task automatic test_halt();
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF ||
            bus.out_halt !== 1'b1 || halted !== 1'b0)
            $display("FAIL halt_accept: got rdy=%b v=%b data=%h oh=%b halted=%b want rdy=0 v=1 data=deadbeef oh=1 halted=0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_halt, halted);
        else pass_cnt++;
        step(1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (occ !== 2'd1 || halted !== 1'b0) $display("FAIL halt_block: got occ=%0d halted=%b want occ=1 halted=0", occ, halted);
        else pass_cnt++;
        step(1'b1, 32'h0000_0066, 1'b0, 1'b1, 1'b0);
        chk_cnt++;
        if (halted !== 1'b1 || occ !== 2'd0 || bus.in_ready !== 1'b0)
            $display("FAIL halt_rise: got halted=%b occ=%0d rdy=%b want halted=1 occ=0 rdy=0", halted, occ, bus.in_ready);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
            chk_cnt++;
            if (halted !== 1'b1 || occ !== 2'd0 || bus.out_valid !== 1'b0)
                $display("FAIL halt_sticky_%0d: got halted=%b occ=%0d v=%b want halted=1 occ=0 v=0", i, halted, occ, bus.out_valid);
            else pass_cnt++;
        end
        do_reset();
        chk_cnt++;
        if (halted !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL halt_reset: got halted=%b rdy=%b want halted=0 rdy=1", halted, bus.in_ready);
        else pass_cnt++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_halt   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_random();
`ifdef PIPE_STAGE_FLUSH_EN
        test_flush();
`endif
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
